vram_arbiter: RTL
=================

// Module: vram_arbiter
// PURPOSE
//  Shares one single-port video bank (red/blue or green plane) between the CRTC-driven video
//  fetch path and the Z80 bus, replacing the true-dual-port arrangement.
//  - Video fetch has priority; a starvation counter guarantees a bounded CPU slot.
//  - CPU accesses use a req/ack handshake plus a wait_n output for the Z80 WAIT line.
//  - All sequencing runs on the system clock, qualified by clock-enable.
// PARAMETERS
//  AW        14  address width of the video bank (words)
//  STARVE    3   max consecutive video grants while cpu_req pending before CPU is forced in
// PORTS
//  clock      in   1   system clock, all logic on posedge
//  reset      in   1   asynchronous, active-low
//  ce         in   1   arbitration enable; state advances only when ce=1
//  vid_req    in   1   one-ce pulse: fetch vid_addr
//  vid_addr   in   AW  video fetch address, sampled with vid_req
//  vid_data   out  8   fetched video byte
//  vid_valid  out  1   one-ce pulse, vid_data valid
//  vid_ovr    out  1   sticky overrun: vid_req arrived with a video request still pending
//  cpu_req    in   1   level; held until cpu_ack
//  cpu_we     in   1   1=write, 0=read; sampled at grant
//  cpu_addr   in   AW  CPU address, sampled at grant
//  cpu_din    in   8   CPU write data, sampled at grant
//  cpu_dout   out  8   CPU read data, valid with cpu_ack
//  cpu_ack    out  1   one-ce pulse, access complete
//  wait_n     out  1   0 while cpu_req=1 and cpu_ack not yet given
//  mem_ce     out  1   RAM enable (1 in grant cycle)
//  mem_we     out  1   RAM write enable
//  mem_addr   out  AW  RAM address
//  mem_din    out  8   RAM write data
//  mem_dout   in   8   RAM read data, registered RAM, valid one ce-cycle after mem_ce
// BEHAVIOUR
//  Reset values
//  - All outputs 0, except wait_n=1.
//  - State IDLE, pending flags clear, starve counter 0, vid_ovr 0.
//  Cycle terminology
//  - "Cycle" means a clock edge with ce=1; with ce=0 all state and outputs hold.
//  Video pending register
//  - vid_req sets vpend and latches vid_addr.
//  - vid_req while vpend=1 and that request is not being granted in the same cycle:
//    vid_ovr <= 1 (sticky until reset); the new address replaces the old one.
//  Grant decision, each cycle, one of:
//  - GV (video): vpend=1 and (starve<STARVE or no CPU pending).
//  - GC (CPU): cpu_req=1, no CPU access in flight (cbusy=0), and (vpend=0 or starve==STARVE).
//  - Else idle: mem_ce=0.
//  Starve counter
//  - Increments on GV while a CPU request is pending (cpu_req=1 and cbusy=0), saturates at STARVE.
//  - Clears on GC, and whenever no CPU request is pending.
//  Pipeline, grant at cycle N
//  - Cycle N: mem_ce=1, mem_addr/mem_we/mem_din driven from the granted source.
//    mem_we=1 only for a CPU write.
//  - Cycle N+1: mem_dout sampled into vid_data or cpu_dout.
//  - Cycle N+2: vid_valid=1 or cpu_ack=1 for exactly one cycle.
//  - Fixed latency 2 for both sources; writes ack at N+2, cpu_dout unchanged on writes.
//  CPU access tracking
//  - cbusy set at GC, cleared with cpu_ack.
//  - cpu_req still high in the cycle after cpu_ack is treated as a new request.
//  - wait_n registered: 0 from the first cycle cpu_req=1 is seen, 1 in the cpu_ack cycle.
//  Pipeline occupancy
//  - At most one access in each pipeline stage, so back-to-back GV,GC,GV is legal.
//  - Results return in issue order.
//  Simultaneous events
//  - vid_req and GV of the previous pending request in the same cycle: no overrun,
//    vpend stays 1 with the new address.
//  Reset mid-operation
//  - Asynchronous clear; in-flight accesses are dropped, no ack/valid is produced.
//  - mem_we=0 immediately.
//  Address width
//  - Addresses pass through unmodified; no wrap or bounds logic.
// TESTING
//  1. vid_req @A=0x0123, no CPU -> mem_ce/addr 0x0123 at N, vid_valid at N+2 with RAM byte.
//  2. CPU write 0x5A @0x0400 then read 0x0400 -> ack at N+2 each, cpu_dout=0x5A,
//     wait_n low until ack.
//  3. vid_req every cycle, STARVE=3, cpu_req high -> exactly 3 GV then 1 GC;
//     vid_ovr=1 on the displaced request; cpu_ack within 6 cycles.
//  4. vid_req and cpu_req in same cycle, starve=0 -> GV first, GC next; vid_valid then cpu_ack
//     on consecutive cycles.
//  5. ce toggling 1-in-4 -> latency is 2 ce-cycles; outputs hold while ce=0.
//  6. reset low one cycle after GC of a write -> no cpu_ack, mem_we=0, wait_n=1, vid_ovr=0.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Video/CPU/RAM bus bundle for the shared video bank arbiter.
// The arbiter takes the slave side; RAM, CRTC and Z80 glue drive the master side.
interface vram_arbiter_if #(
  parameter int AW = 14
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_data;
  logic          vid_valid;
  logic          vid_ovr;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;
  logic          wait_n;
  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;

  modport slave (
    input  vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  mem_dout,
    output vid_data, vid_valid, vid_ovr,
    output cpu_dout, cpu_ack, wait_n,
    output mem_ce, mem_we, mem_addr, mem_din
  );

  modport master (
    output vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output mem_dout,
    input  vid_data, vid_valid, vid_ovr,
    input  cpu_dout, cpu_ack, wait_n,
    input  mem_ce, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port video bank arbiter: video fetch first, CPU slot
// guaranteed by a starvation counter, fixed 2-cycle read pipeline.
module vram_arbiter #(
  parameter int AW     = 14,
  parameter int STARVE = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  vram_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE);

  typedef enum logic [1:0] {
    IDLE,
    VID,
    CPU
  } slot_t;

  slot_t         st1;
  slot_t         st2;
  logic          vpend;
  logic [AW-1:0] vaddr;
  logic          cbusy;
  logic          s2_we;
  logic [SW-1:0] starve;

  logic cwait;
  logic cpu_pend;
  logic gc;
  logic gv;
  logic ack_now;

  // wait_n low doubles as "CPU request has been seen"
  assign cwait    = ~bus.wait_n;
  assign cpu_pend = cwait & bus.cpu_req & ~cbusy;
  assign gc       = cpu_pend & (~vpend | (starve == SMAX));
  assign gv       = vpend & ~gc;
  assign ack_now  = (st2 == CPU);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st1           <= IDLE;
      st2           <= IDLE;
      vpend         <= 1'b0;
      vaddr         <= '0;
      cbusy         <= 1'b0;
      s2_we         <= 1'b0;
      starve        <= '0;
      bus.vid_data  <= '0;
      bus.vid_valid <= 1'b0;
      bus.vid_ovr   <= 1'b0;
      bus.cpu_dout  <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.wait_n    <= 1'b1;
      bus.mem_ce    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_din   <= '0;
    end else if (ce) begin
      // a request granted this cycle frees the slot for the new one
      if (bus.vid_req) begin
        vpend <= 1'b1;
        vaddr <= bus.vid_addr;
        if (vpend && !gv)
          bus.vid_ovr <= 1'b1;
      end else if (gv) begin
        vpend <= 1'b0;
      end

      if (!bus.cpu_req || cbusy || gc)
        starve <= '0;
      else if (gv && starve != SMAX)
        starve <= starve + SW'(1);

      bus.mem_ce <= gv | gc;
      bus.mem_we <= gc & bus.cpu_we;
      unique case (1'b1)
        gc: begin
          st1          <= CPU;
          bus.mem_addr <= bus.cpu_addr;
          bus.mem_din  <= bus.cpu_din;
        end
        gv: begin
          st1          <= VID;
          bus.mem_addr <= vaddr;
        end
        default: st1 <= IDLE;
      endcase

      st2   <= st1;
      s2_we <= bus.mem_we;

      bus.vid_valid <= (st2 == VID);
      bus.cpu_ack   <= ack_now;
      if (st2 == VID)
        bus.vid_data <= bus.mem_dout;
      if (ack_now && !s2_we)
        bus.cpu_dout <= bus.mem_dout;

      if (gc)
        cbusy <= 1'b1;
      else if (ack_now)
        cbusy <= 1'b0;

      bus.wait_n <= ack_now | ~bus.cpu_req;
    end
  end
endmodule
